mtl_timing_gen: RTL and testbench
=================================

MTL_TIMING_GEN -- requirements
Module: mtl_timing_gen

Interface
Parameters (name, default, meaning):
REQ-001 H_ACT, 800: active pixels per line.
REQ-002 H_BACK, 46: horizontal blanking before active region, sync pulse included.
REQ-003 H_TOTAL, 1056: clocks per line.
REQ-004 H_SYNC, 30: HD pulse width in clocks.
REQ-005 V_ACT, 480: active lines per frame.
REQ-006 V_BACK, 23: vertical blanking lines before active region, sync pulse included.
REQ-007 V_TOTAL, 525: lines per frame.
REQ-008 V_SYNC, 13: VD pulse width in lines.
REQ-009 PIPE_LAT, 3: pixel-renderer latency in clocks, from x_cnt/y_cnt to RGB; legal range 1..8.

Ports (name, direction, width, meaning):
REQ-010 CLK_33  in  1  33 MHz pixel clock; sole clock of the block.
REQ-011 reset  in  1  asynchronous, active-low reset.
REQ-012 pix_red/pix_green/pix_blue  in  8 each  renderer colour for the coordinate issued PIPE_LAT clocks earlier.
REQ-013 x_cnt  out  11  horizontal coordinate issued to the renderers.
REQ-014 y_cnt  out  10  vertical coordinate issued to the renderers.
REQ-015 frame_start  out  1  one-clock pulse at coordinate (0,0).
REQ-016 HD  out  1  horizontal sync to the panel, active-low.
REQ-017 VD  out  1  vertical sync to the panel, active-low.
REQ-018 DEN  out  1  data enable to the panel, active-high.
REQ-019 LCD_R/LCD_G/LCD_B  out  8 each  panel colour.

Function
REQ-020 x_cnt SHALL increment on every CLK_33 edge and wrap from H_TOTAL-1 to 0.
REQ-021 y_cnt SHALL increment only on the x_cnt wrap and wrap from V_TOTAL-1 to 0 when x_cnt also wraps.
REQ-022 Counter arithmetic SHALL be unsigned, with explicit terminal-count compares; no free-running overflow.
REQ-023 frame_start SHALL be 1 exactly while x_cnt==0 and y_cnt==0, driven from registers with no combinational path from inputs.
REQ-024 Raw timing signals, computed from the current x_cnt/y_cnt:
- hs_raw = 0 when x_cnt < H_SYNC.
- vs_raw = 0 when y_cnt < V_SYNC.
- de_raw = 1 when H_BACK <= x_cnt < H_BACK+H_ACT and V_BACK <= y_cnt < V_BACK+V_ACT.
REQ-025 hs_raw, vs_raw and de_raw SHALL pass through a PIPE_LAT-deep shift register, then one output register, so HD/VD/DEN appear PIPE_LAT+1 clocks after their coordinate.
REQ-026 LCD_R/G/B SHALL be registered pix_* when the delayed DE at stage PIPE_LAT is 1, and 8'd0 otherwise, so colour is aligned cycle-for-cycle with DEN.
REQ-027 Line period SHALL be H_TOTAL clocks, frame period H_TOTAL*V_TOTAL clocks, and DEN-high clocks per frame exactly H_ACT*V_ACT.
REQ-028 The block SHALL keep running continuously with no stall or enable; a pix_* change outside DEN SHALL have no effect on any output.

Reset
REQ-029 While reset==0, all state SHALL clear asynchronously, with no clock edge needed:
- x_cnt=0, y_cnt=0, frame_start=0.
- HD=1, VD=1, DEN=0, LCD_R/G/B=0.
- every delay-line stage set to its inactive value: hs=1, vs=1, de=0.
REQ-030 On the first CLK_33 edge after reset rises, x_cnt SHALL become 1; frame_start SHALL be 1 during the clock between reset release and that edge.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release, timing SHALL restart from (0,0) with no partial DEN burst from the aborted frame.

Verification
REQ-032 Line wrap: release reset, count 1055 edges -> x_cnt=1055, y_cnt=0; next edge -> x_cnt=0, y_cnt=1.
REQ-033 Frame wrap: at x_cnt=1055, y_cnt=524, one edge -> (0,0) and frame_start=1 for exactly one clock; frame_start period 554400 clocks.
REQ-034 Sync timing, PIPE_LAT=3: HD low for 30 clocks starting 4 clocks after x_cnt=0, period 1056; VD low for 13*1056 clocks per frame.
REQ-035 Data enable: first DEN=1 occurs 4 clocks after (x_cnt=46, y_cnt=23); 800 consecutive DEN=1 per active line; 480 active lines; 384000 DEN=1 clocks per frame.
REQ-036 Colour gating: pix_red held at 8'hFF -> LCD_R=8'hFF only when DEN=1, else 8'h00; a one-clock pix_red marker issued at x_cnt=100 appears on LCD_R together with that pixel's DEN.
REQ-037 Asynchronous reset: drop reset at x_cnt=500, y_cnt=200 between edges -> outputs at reset values before the next edge; after release, the counters restart at (0,0).

Source files
------------

// File: rtl/mtl_timing_gen.sv
// LCD panel timing generator: raster counters, sync/DE generation, and a delay line
// that lines HD/VD/DEN up with the pixel renderer's output latency.
module mtl_timing_gen #(
  parameter int H_ACT    = 800,
  parameter int H_BACK   = 46,
  parameter int H_TOTAL  = 1056,
  parameter int H_SYNC   = 30,
  parameter int V_ACT    = 480,
  parameter int V_BACK   = 23,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 13,
  parameter int PIPE_LAT = 3
) (
  input  logic        CLK_33,
  input  logic        reset,
  input  logic [7:0]  pix_red,
  input  logic [7:0]  pix_green,
  input  logic [7:0]  pix_blue,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        frame_start,
  output logic        HD,
  output logic        VD,
  output logic        DEN,
  output logic [7:0]  LCD_R,
  output logic [7:0]  LCD_G,
  output logic [7:0]  LCD_B
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYN_C = 11'(H_SYNC);
  localparam logic [10:0] H_DE_LO = 11'(H_BACK);
  localparam logic [10:0] H_DE_HI = 11'(H_BACK + H_ACT);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYN_C = 10'(V_SYNC);
  localparam logic [9:0]  V_DE_LO = 10'(V_BACK);
  localparam logic [9:0]  V_DE_HI = 10'(V_BACK + V_ACT);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        fs_q, fs_d;
  logic        x_wrap, y_wrap;
  logic        hs_raw, vs_raw, de_raw;

  logic [PIPE_LAT-1:0] hs_dly_q, hs_dly_d;
  logic [PIPE_LAT-1:0] vs_dly_q, vs_dly_d;
  logic [PIPE_LAT-1:0] de_dly_q, de_dly_d;

  logic       hd_q, hd_d, vd_q, vd_d, den_q, den_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_wrap ? 11'd0 : x_q + 11'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : y_q + 10'd1;
    end
    // Flag the upcoming (0,0) so frame_start comes straight off a flop.
    fs_d   = x_wrap && y_wrap;

    hs_raw = !(x_q < H_SYN_C);
    vs_raw = !(y_q < V_SYN_C);
    de_raw = (x_q >= H_DE_LO) && (x_q < H_DE_HI) &&
             (y_q >= V_DE_LO) && (y_q < V_DE_HI);
  end

  always_comb begin
    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    de_dly_d    = de_dly_q;
    hs_dly_d[0] = hs_raw;
    vs_dly_d[0] = vs_raw;
    de_dly_d[0] = de_raw;
    for (int i = 1; i < PIPE_LAT; i++) begin
      hs_dly_d[i] = hs_dly_q[i-1];
      vs_dly_d[i] = vs_dly_q[i-1];
      de_dly_d[i] = de_dly_q[i-1];
    end
  end

  // The last delay stage lines up with the renderer's colour for the same coordinate.
  always_comb begin
    hd_d  = hs_dly_q[PIPE_LAT-1];
    vd_d  = vs_dly_q[PIPE_LAT-1];
    den_d = de_dly_q[PIPE_LAT-1];
    r_d   = den_d ? pix_red   : 8'd0;
    g_d   = den_d ? pix_green : 8'd0;
    b_d   = den_d ? pix_blue  : 8'd0;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b1;
      hs_dly_q <= '1;
      vs_dly_q <= '1;
      de_dly_q <= '0;
      hd_q     <= 1'b1;
      vd_q     <= 1'b1;
      den_q    <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= fs_d;
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
      de_dly_q <= de_dly_d;
      hd_q     <= hd_d;
      vd_q     <= vd_d;
      den_q    <= den_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  // fs_q sits at 1 through reset so the pulse is already up in the clock after release.
  assign frame_start = fs_q & reset;
  assign x_cnt       = x_q;
  assign y_cnt       = y_q;
  assign HD          = hd_q;
  assign VD          = vd_q;
  assign DEN         = den_q;
  assign LCD_R       = r_q;
  assign LCD_G       = g_q;
  assign LCD_B       = b_q;

endmodule

// File: tb/tb_mtl_timing_gen.sv
// Bench for mtl_timing_gen with a shrunken raster; expectations come from a
// cycle-indexed arithmetic model of the raster and the pixel history.
module tb_mtl_timing_gen;

  localparam int HA = 20, HB = 6, HT = 32, HS = 3;
  localparam int VA = 10, VB = 4, VT = 16, VS = 2;
  localparam int L = 3;
  localparam int FRAME = HT * VT;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pr = '0, pg = '0, pb = '0;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        frame_start, HD, VD, DEN;
  logic [7:0]  LCD_R, LCD_G, LCD_B;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [7:0] hr [MAXC];
  logic [7:0] hg [MAXC];
  logic [7:0] hb [MAXC];

  mtl_timing_gen #(
    .H_ACT(HA), .H_BACK(HB), .H_TOTAL(HT), .H_SYNC(HS),
    .V_ACT(VA), .V_BACK(VB), .V_TOTAL(VT), .V_SYNC(VS), .PIPE_LAT(L)
  ) dut (
    .CLK_33(clk), .reset(rst),
    .pix_red(pr), .pix_green(pg), .pix_blue(pb),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_start(frame_start),
    .HD(HD), .VD(VD), .DEN(DEN),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
  );

  always #5 clk = ~clk;

  // Model: t counts clock edges since reset release; coordinate issued at cycle c
  // is (c mod HT, (c div HT) mod VT); panel signals show it L+1 cycles later.
  function automatic int mx(int c); return c % HT; endfunction
  function automatic int my(int c); return (c / HT) % VT; endfunction
  function automatic logic exp_hs(int tt);
    if (tt < L + 1) return 1'b1;
    return (mx(tt - L - 1) >= HS);
  endfunction
  function automatic logic exp_vs(int tt);
    if (tt < L + 1) return 1'b1;
    return (my(tt - L - 1) >= VS);
  endfunction
  function automatic logic exp_de(int tt);
    int c;
    if (tt < L + 1) return 1'b0;
    c = tt - L - 1;
    return (mx(c) >= HB) && (mx(c) < HB + HA) && (my(c) >= VB) && (my(c) < VB + VA);
  endfunction
  function automatic logic [48:0] exp_vec(int tt);
    logic [23:0] rgb;
    rgb = exp_de(tt) ? {hr[tt-1], hg[tt-1], hb[tt-1]} : 24'd0;
    return {11'(mx(tt)), 10'(my(tt)), (mx(tt) == 0 && my(tt) == 0),
            exp_hs(tt), exp_vs(tt), exp_de(tt), rgb};
  endfunction
  function automatic logic [48:0] obs_vec();
    return {x_cnt, y_cnt, frame_start, HD, VD, DEN, LCD_R, LCD_G, LCD_B};
  endfunction

  task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pr = r; pg = g; pb = b;
    hr[t] = r; hg[t] = g; hb[t] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    t = 0;
    #1;
    set_pix(8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== {11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0}) begin
      errors++;
      $display("FAIL reset_values actual=%h expected=%h", obs_vec(),
               {11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0});
    end
    @(negedge clk);
    rst = 1'b1;
    t = 0;
    #1;
    set_pix(8'hAA, 8'hBB, 8'hCC);
    checks++;
    if (frame_start !== 1'b1 || x_cnt !== 11'd0) begin
      errors++;
      $display("FAIL release_frame_start actual fs=%b x=%0d required fs=1 x=0", frame_start, x_cnt);
    end
    step();
    checks++;
    if (x_cnt !== 11'd1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL first_edge actual x=%0d fs=%b required x=1 fs=0", x_cnt, frame_start);
    end
  endtask

  task automatic test_frame_random();
    int den_cnt = 0;
    int fs_first = -1, fs_second = -1;
    do_reset();
    for (int n = 0; n < 2 * FRAME + 20; n++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(t)) begin
        errors++;
        $display("FAIL frame_cycle t=%0d actual=%h expected=%h", t, obs_vec(), exp_vec(t));
      end
      if (t >= L + 1 && t < L + 1 + FRAME && DEN === 1'b1) den_cnt++;
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = t;
        else if (fs_second < 0) fs_second = t;
      end
      if (t == HT - 1) begin
        checks++;
        if (x_cnt !== 11'(HT - 1) || y_cnt !== 10'd0) begin
          errors++;
          $display("FAIL line_end actual x=%0d y=%0d required x=%0d y=0", x_cnt, y_cnt, HT - 1);
        end
      end
      if (t == HT) begin
        checks++;
        if (x_cnt !== 11'd0 || y_cnt !== 10'd1) begin
          errors++;
          $display("FAIL line_wrap actual x=%0d y=%0d required x=0 y=1", x_cnt, y_cnt);
        end
      end
      set_pix(8'($urandom), 8'($urandom), 8'($urandom));
    end
    checks++;
    if (den_cnt != HA * VA) begin
      errors++;
      $display("FAIL den_per_frame actual=%0d required=%0d", den_cnt, HA * VA);
    end
    checks++;
    if (fs_first != FRAME || fs_second != 2 * FRAME) begin
      errors++;
      $display("FAIL frame_period actual first=%0d second=%0d required %0d %0d",
               fs_first, fs_second, FRAME, 2 * FRAME);
    end
  endtask

  task automatic test_color_gating();
    int tm;
    logic [7:0] er;
    tm = (VB + 2) * HT + HB + 5;
    do_reset();
    set_pix(8'hFF, 8'($urandom), 8'($urandom));
    while (t < tm + L + HT) begin
      step();
      er = exp_de(t) ? hr[t-1] : 8'h00;
      checks++;
      if (LCD_R !== er || DEN !== exp_de(t)) begin
        errors++;
        $display("FAIL color_gate t=%0d actual R=%h DEN=%b required R=%h DEN=%b",
                 t, LCD_R, DEN, er, exp_de(t));
      end
      if (t == tm + L + 1) begin
        checks++;
        if (LCD_R !== 8'h5A || DEN !== 1'b1) begin
          errors++;
          $display("FAIL marker actual R=%h DEN=%b required R=5a DEN=1", LCD_R, DEN);
        end
      end
      set_pix((t == tm + L) ? 8'h5A : 8'hFF, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_async_reset_mid();
    int tgt;
    tgt = (VB + 5) * HT + HB + 4;
    do_reset();
    while (t < tgt) begin
      step();
      set_pix(8'($urandom), 8'($urandom), 8'($urandom));
    end
    checks++;
    if (DEN !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_den actual=%b required=1", DEN);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== {11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0}) begin
      errors++;
      $display("FAIL async_reset actual=%h expected=%h", obs_vec(),
               {11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0});
    end
    @(negedge clk);
    rst = 1'b1;
    t = 0;
    #1;
    set_pix(8'($urandom), 8'($urandom), 8'($urandom));
    checks++;
    if (obs_vec() !== exp_vec(0)) begin
      errors++;
      $display("FAIL restart t=0 actual=%h expected=%h", obs_vec(), exp_vec(0));
    end
    for (int n = 0; n < FRAME + 10; n++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(t)) begin
        errors++;
        $display("FAIL restart t=%0d actual=%h expected=%h", t, obs_vec(), exp_vec(t));
      end
      set_pix(8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_frame_random();
    test_color_gating();
    test_async_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
